// File: rtl/vector_lsu.sv
// Strided vector load/store unit: serialises one R-lane vector into one memory
// beat per enabled lane, lane 0 first, and gathers load data back into rdata.
module vector_lsu #(
    parameter int I = 32,
    parameter int N = 8,
    parameter int R = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                ready,
    input  logic                we,
    input  logic [I-1:0]        base,
    input  logic [I-1:0]        stride,
    input  logic [R-1:0]        mask,
    input  logic [R-1:0][N-1:0] wdata,
    output logic [R-1:0][N-1:0] rdata,
    output logic                done,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [I-1:0]        mem_addr,
    output logic [N-1:0]        mem_wdata,
    input  logic [N-1:0]        mem_rdata
);
    localparam int LW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [I-1:0]        base_q, base_d;
    logic [I-1:0]        stride_q, stride_d;
    logic [R-1:0][N-1:0] wdata_q, wdata_d;
    logic [R-1:0]        pend_q, pend_d;
    logic                capValid_q, capValid_d;
    logic [LW-1:0]       capLane_q, capLane_d;
    logic [R-1:0][N-1:0] rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                memReq_q, memReq_d;
    logic                memWe_q, memWe_d;
    logic [I-1:0]        memAddr_q, memAddr_d;
    logic [N-1:0]        memWdata_q, memWdata_d;

    logic [LW-1:0]       curLane, nextLane, startLane;
    logic [R-1:0]        pendNext;

    function automatic logic [LW-1:0] firstLane(input logic [R-1:0] m);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (m[i]) idx = LW'(i);
        end
        return idx;
    endfunction

    function automatic logic [I-1:0] laneAddr(input logic [I-1:0] b, input logic [I-1:0] s,
                                              input logic [LW-1:0] lane);
        return b + I'(lane) * s;
    endfunction

    // pend_q holds the enabled lanes not yet granted; its lowest set bit is the live beat.
    always_comb begin
        curLane   = firstLane(pend_q);
        pendNext  = pend_q;
        pendNext[curLane] = 1'b0;
        nextLane  = firstLane(pendNext);
        startLane = firstLane(mask);
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        base_d     = base_q;
        stride_d   = stride_q;
        wdata_d    = wdata_q;
        pend_d     = pend_q;
        capValid_d = 1'b0;
        capLane_d  = capLane_q;
        rdata_d    = rdata_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;

        // Load data arrives one cycle after its grant, tagged by the lane granted then.
        if (capValid_q) rdata_d[capLane_q] = mem_rdata;

        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d     = we;
                    base_d   = base;
                    stride_d = stride;
                    wdata_d  = wdata;
                    memWe_d  = we;
                    if (!we) rdata_d = '0;
                    if (mask == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ISSUE;
                        pend_d     = mask;
                        memReq_d   = 1'b1;
                        memAddr_d  = laneAddr(base, stride, startLane);
                        memWdata_d = wdata[startLane];
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    pend_d = pendNext;
                    if (!we_q) begin
                        capValid_d = 1'b1;
                        capLane_d  = curLane;
                    end
                    if (pendNext == '0) begin
                        memReq_d = 1'b0;
                        state_d  = we_q ? DONE : DRAIN;
                    end else begin
                        memAddr_d  = laneAddr(base_q, stride_q, nextLane);
                        memWdata_d = wdata_q[nextLane];
                    end
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            wdata_q    <= '0;
            pend_q     <= '0;
            capValid_q <= 1'b0;
            capLane_q  <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            wdata_q    <= wdata_d;
            pend_q     <= pend_d;
            capValid_q <= capValid_d;
            capLane_q  <= capLane_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: a memory model returns addr[7:0] one cycle
// after each grant, and every check goes through checkOutput.
module tb_vector_lsu;
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             ready;
    logic             we = 1'b0;
    logic [31:0]      base = '0;
    logic [31:0]      stride = '0;
    logic [5:0]       mask = '0;
    logic [5:0][7:0]  wdata = '0;
    logic [5:0][7:0]  rdata;
    logic             done;
    logic             mem_req;
    logic             mem_gnt = 1'b1;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata = '0;

    int total = 0;
    int bad = 0;

    int          nBeats;
    int          doneCycle;
    int          reqCycles;
    logic [31:0] beatAddr [8];
    logic [7:0]  beatData [8];
    logic        beatWe   [8];
    int          beatCycle[8];

    vector_lsu #(.I(32), .N(8), .R(6)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .we(we),
        .base(base), .stride(stride), .mask(mask), .wdata(wdata), .rdata(rdata),
        .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= (mem_req && mem_gnt) ? mem_addr[7:0] : 8'hEE;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepts one operation at cycle 0, then logs beats and done per cycle.
    task automatic applyStimulus(input logic iwe, input logic [31:0] ibase, input logic [31:0] istride,
                                 input logic [5:0] imask, input logic [47:0] iwdata,
                                 input int stallBeat, input int stallCycles,
                                 input logic [31:0] stallAddr, input int pokeCycle);
        int stallLeft;
        stallLeft = stallCycles;
        nBeats    = 0;
        doneCycle = -1;
        reqCycles = 0;
        @(negedge clk);
        we = iwe; base = ibase; stride = istride; mask = imask; wdata = iwdata;
        start = 1'b1; mem_gnt = 1'b1;
        for (int c = 1; c <= 40 && doneCycle < 0; c++) begin
            @(negedge clk);
            start = (c == pokeCycle);
            if (c == pokeCycle) begin
                base = 32'h5555; mask = 6'h3f; we = ~iwe;
            end
            mem_gnt = !(mem_req && nBeats == stallBeat && stallLeft > 0);
            if (!mem_gnt) begin
                stallLeft--;
                checkOutput("stall_addr", mem_addr, stallAddr);
            end
            if (mem_req) reqCycles++;
            if (mem_req && mem_gnt && nBeats < 8) begin
                beatAddr[nBeats]  = mem_addr;
                beatData[nBeats]  = mem_wdata;
                beatWe[nBeats]    = mem_we;
                beatCycle[nBeats] = c;
                nBeats++;
            end
            if (done) doneCycle = c;
        end
        start = 1'b0; mem_gnt = 1'b1;
        if (doneCycle < 0) checkOutput("done_timeout", 0, 1);
        @(negedge clk);
        checkOutput("ready_after", {63'd0, ready}, 1);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {63'd0, ready}, 1);
        checkOutput("rst_done", {63'd0, done}, 0);
        checkOutput("rst_req", {63'd0, mem_req}, 0);
        checkOutput("rst_we", {63'd0, mem_we}, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        reset = 1'b1;

        $display("[TB] full load, base 0x100 stride 1");
        applyStimulus(1'b0, 32'h100, 32'd1, 6'h3f, 48'h0, -1, 0, 0, -1);
        checkOutput("t1_beats", nBeats, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t1_addr", beatAddr[i], 32'h100 + i);
            checkOutput("t1_cycle", beatCycle[i], i + 1);
        end
        checkOutput("t1_we", {63'd0, beatWe[0]}, 0);
        checkOutput("t1_req", reqCycles, 6);
        checkOutput("t1_done", doneCycle, 8);
        checkOutput("t1_rdata", rdata, 48'h050403020100);

        $display("[TB] sparse load, masked lanes read zero");
        applyStimulus(1'b0, 32'h40, 32'h10, 6'b100110, 48'h0, -1, 0, 0, -1);
        checkOutput("t6_beats", nBeats, 3);
        checkOutput("t6_addr0", beatAddr[0], 32'h50);
        checkOutput("t6_addr1", beatAddr[1], 32'h60);
        checkOutput("t6_addr2", beatAddr[2], 32'h90);
        checkOutput("t6_done", doneCycle, 5);
        checkOutput("t6_rdata", rdata, 48'h900000605000);

        $display("[TB] sparse store, base 0x10 stride 4");
        applyStimulus(1'b1, 32'h10, 32'd4, 6'b000101, 48'h665544332211, -1, 0, 0, -1);
        checkOutput("t2_beats", nBeats, 2);
        checkOutput("t2_addr0", beatAddr[0], 32'h10);
        checkOutput("t2_data0", beatData[0], 8'h11);
        checkOutput("t2_addr1", beatAddr[1], 32'h18);
        checkOutput("t2_data1", beatData[1], 8'h33);
        checkOutput("t2_we", {63'd0, beatWe[1]}, 1);
        checkOutput("t2_done", doneCycle, 3);
        checkOutput("t2_rdata_kept", rdata, 48'h900000605000);

        $display("[TB] load with 3-cycle grant stall on lane 1");
        applyStimulus(1'b0, 32'h200, 32'd2, 6'h3f, 48'h0, 1, 3, 32'h202, -1);
        checkOutput("t3_beats", nBeats, 6);
        checkOutput("t3_addr1", beatAddr[1], 32'h202);
        checkOutput("t3_addr5", beatAddr[5], 32'h20A);
        checkOutput("t3_req", reqCycles, 9);
        checkOutput("t3_done", doneCycle, 11);
        checkOutput("t3_rdata", rdata, 48'h0A0806040200);

        $display("[TB] empty mask");
        applyStimulus(1'b0, 32'h300, 32'd1, 6'h00, 48'h0, -1, 0, 0, -1);
        checkOutput("t4_beats", nBeats, 0);
        checkOutput("t4_req", reqCycles, 0);
        checkOutput("t4_done", doneCycle, 1);
        checkOutput("t4_rdata", rdata, 0);

        $display("[TB] wrapping addresses, start poked while busy");
        applyStimulus(1'b0, 32'hFFFFFFFE, 32'd1, 6'h3f, 48'h0, -1, 0, 0, 2);
        checkOutput("t5_beats", nBeats, 6);
        checkOutput("t5_addr0", beatAddr[0], 32'hFFFFFFFE);
        checkOutput("t5_addr1", beatAddr[1], 32'hFFFFFFFF);
        checkOutput("t5_addr2", beatAddr[2], 32'h0);
        checkOutput("t5_addr5", beatAddr[5], 32'h3);
        checkOutput("t5_done", doneCycle, 8);
        checkOutput("t5_rdata", rdata, 48'h03020100FFFE);
        @(negedge clk);
        checkOutput("t5_no_queue", {63'd0, mem_req}, 0);

        $display("[TB] reset during lane 3 of a load");
        we = 1'b0; base = 32'h300; stride = 32'd1; mask = 6'h3f; start = 1'b1; mem_gnt = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("r_addr_lane3", mem_addr, 32'h303);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("r_req", {63'd0, mem_req}, 0);
        checkOutput("r_ready", {63'd0, ready}, 1);
        checkOutput("r_rdata", rdata, 0);
        checkOutput("r_addr", mem_addr, 0);
        begin
            int doneSeen;
            doneSeen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done || mem_req) doneSeen++;
            end
            checkOutput("r_no_done", doneSeen, 0);
        end
        checkOutput("r_discard", rdata, 0);

        $display("[TB] load after reset abort");
        applyStimulus(1'b0, 32'h20, 32'd3, 6'b000011, 48'h0, -1, 0, 0, -1);
        checkOutput("t7_beats", nBeats, 2);
        checkOutput("t7_addr1", beatAddr[1], 32'h23);
        checkOutput("t7_done", doneCycle, 4);
        checkOutput("t7_rdata", rdata, 48'h000000002320);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
